// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shared-multiplier controller: FSM encoding,
// port count and the registered per-request control fields.
package mult_ctrl_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Control captured at accept time; operands are held separately since
    // their width depends on the instance parameter N.
    typedef struct packed {
        logic owner;
        logic sgn;
        logic full;
    } req_ctl_t;

endpackage

// File: rtl/mult_share_ctrl_mul.sv
// Combinational N x N multiplier returning one half of the 2N-bit product.
// HiLo selects the half, Signed selects two's-complement operands.
module mult_share_ctrl_mul #(
    parameter int N = 8
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         HiLo,
    input  logic         Signed,
    output logic [N-1:0] Out
);

    // Extending straight to 2N bits gives the same low 2N product bits as an
    // (N+1)-bit signed multiply, and leaves no unused upper product bits.
    logic [2*N-1:0] xe, ye, prod;

    // Operand extension and product half select
    always_comb begin
        xe   = Signed ? {{N{X[N-1]}}, X} : {{N{1'b0}}, X};
        ye   = Signed ? {{N{Y[N-1]}}, Y} : {{N{1'b0}}, Y};
        prod = xe * ye;
        Out  = HiLo ? prod[2*N-1:N] : prod[N-1:0];
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Two-port round-robin front end for a single shared multiplier. Each request
// takes one cycle for the low half and, if requested, one for the high half,
// then holds the result until the owning port accepts it.
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_INIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] in_valid,
    output logic [NUM_PORTS-1:0] in_ready,
    input  logic [N-1:0]         in_x0,
    input  logic [N-1:0]         in_y0,
    input  logic [N-1:0]         in_x1,
    input  logic [N-1:0]         in_y1,
    input  logic [NUM_PORTS-1:0] in_signed,
    input  logic [NUM_PORTS-1:0] in_full,
    output logic [NUM_PORTS-1:0] out_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [N-1:0]         out_lo,
    output logic [N-1:0]         out_hi,
    output logic                 busy
);

    logic [1:0]   state;
    logic         last_served;
    req_ctl_t     ctl;
    logic [N-1:0] x_r, y_r, lo_reg, hi_reg, mul_out;
    logic         gnt_vld, gnt, accept;

    // Grant: lone requester wins; on a tie the port not served last wins
    always_comb begin
        gnt_vld = |in_valid;
        gnt     = 1'b0;
        if (in_valid == 2'b11) gnt = ~last_served;
        else                   gnt = in_valid[1];
    end

    // in_ready is held low while reset is asserted even if requests are present
    assign in_ready = (!rst && state == S_IDLE && gnt_vld) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign accept   = |(in_valid & in_ready);
    assign busy     = (state != S_IDLE);

    mult_share_ctrl_mul #(.N(N)) u_mul (
        .X      (x_r),
        .Y      (y_r),
        .HiLo   (state == S_HI),
        .Signed (ctl.sgn),
        .Out    (mul_out)
    );

    // Request FSM: capture on accept, low half, optional high half, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_served <= 1'(RR_INIT);
            ctl         <= '0;
            x_r         <= '0;
            y_r         <= '0;
            lo_reg      <= '0;
            hi_reg      <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    ctl   <= '{owner: gnt, sgn: in_signed[gnt], full: in_full[gnt]};
                    x_r   <= gnt ? in_x1 : in_x0;
                    y_r   <= gnt ? in_y1 : in_y0;
                    state <= S_LO;
                end
                S_LO: begin
                    lo_reg <= mul_out;
                    state  <= ctl.full ? S_HI : S_DONE;
                end
                S_HI: begin
                    hi_reg <= mul_out;
                    state  <= S_DONE;
                end
                S_DONE: if (out_ready[ctl.owner]) begin
                    last_served <= ctl.owner;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result bus is driven only in DONE; a lo-only request reports hi as zero
    assign out_valid = (state == S_DONE) ? (ctl.owner ? 2'b10 : 2'b01) : 2'b00;
    assign out_lo    = (state == S_DONE) ? lo_reg : '0;
    assign out_hi    = (state == S_DONE && ctl.full) ? hi_reg : '0;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: reset values, fixed vector table, round-robin
// alternation, result hold under backpressure, randomized traffic against a
// plain-arithmetic model, and reset in the middle of an operation.
module tb_mult_share_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   in_valid, in_ready, in_signed, in_full;
    logic [1:0]   out_valid, out_ready;
    logic [N-1:0] in_x0, in_y0, in_x1, in_y1, out_lo, out_hi;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int last   = 1;   // model of the last-served port

    mult_share_ctrl #(.N(N), .RR_INIT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1),
        .in_signed(in_signed), .in_full(in_full),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo(out_lo), .out_hi(out_hi), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p;
        logic [7:0] x, y;
        logic       s, f;
        int         hold;
        logic [7:0] lo, hi;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: product of the operands read as plain integers
    function automatic void ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s,
                                    input logic f, output logic [7:0] lo, output logic [7:0] hi);
        longint xv, yv, p;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        p  = xv * yv;
        lo = p[7:0];
        hi = f ? p[15:8] : 8'h00;
    endfunction

    task automatic set_port(input int p, input logic [7:0] x, input logic [7:0] y,
                            input logic s, input logic f);
        if (p == 0) begin in_x0 = x; in_y0 = y; end
        else        begin in_x1 = x; in_y1 = y; end
        in_signed[p] = s;
        in_full[p]   = f;
    endtask

    // One request from port p; both=1 also raises the other port's valid
    task automatic txn(input string nm, input int p, input bit both,
                       input logic [7:0] x, input logic [7:0] y, input logic s, input logic f,
                       input int hold, input logic [7:0] elo, input logic [7:0] ehi, input int elat);
        logic [1:0] pm;
        int         lat;
        bit         seen;
        pm = 2'b01 << p;
        @(posedge clk); #1;
        set_port(p, x, y, s, f);
        if (both) set_port(1 - p, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        in_valid = both ? 2'b11 : pm;
        @(negedge clk);
        chk({nm, "/in_ready"}, 32'(in_ready), 32'(pm));
        @(posedge clk); #1;
        in_valid = 2'b00;
        set_port(p, ~x, y + 8'd1, ~s, f);
        lat  = 1;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (out_valid[p]) seen = 1;
            else              lat++;
        end
        chk({nm, "/seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({nm, "/lat"}, 32'(lat), 32'(elat));
            chk({nm, "/out_valid"}, 32'(out_valid), 32'(pm));
            chk({nm, "/lo"}, 32'(out_lo), 32'(elo));
            chk({nm, "/hi"}, 32'(out_hi), 32'(ehi));
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            out_ready = ~pm;
            in_valid  = 2'b11;
            set_port(p, x ^ 8'h5A, y ^ 8'hA5, ~s, f);
            @(negedge clk);
            chk({nm, "/hold_valid"}, 32'(out_valid), 32'(pm));
            chk({nm, "/hold_lo"}, 32'(out_lo), 32'(elo));
            chk({nm, "/hold_hi"}, 32'(out_hi), 32'(ehi));
            chk({nm, "/hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 2'b00;
        out_ready = pm;
        @(posedge clk); #1;
        out_ready = 2'b00;
        @(negedge clk);
        chk({nm, "/idle_busy"}, 32'(busy), 32'd0);
        chk({nm, "/idle_valid"}, 32'(out_valid), 32'd0);
        last = p;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last = 1;
    endtask

    vec_t tbl[7];

    initial begin
        logic [7:0] rx, ry, elo, ehi;
        logic       rs, rf;
        int         p, ngr, exp_g;
        bit         both;

        tbl[0] = '{p: 0, x: 8'hFD, y: 8'h05, s: 1, f: 1, hold: 0, lo: 8'hF1, hi: 8'hFF, lat: 3};
        tbl[1] = '{p: 1, x: 8'hFF, y: 8'hFF, s: 0, f: 1, hold: 0, lo: 8'h01, hi: 8'hFE, lat: 3};
        tbl[2] = '{p: 0, x: 8'h80, y: 8'h80, s: 1, f: 0, hold: 0, lo: 8'h00, hi: 8'h00, lat: 2};
        tbl[3] = '{p: 1, x: 8'h80, y: 8'h80, s: 1, f: 1, hold: 1, lo: 8'h00, hi: 8'h40, lat: 3};
        tbl[4] = '{p: 0, x: 8'h0F, y: 8'h11, s: 0, f: 0, hold: 5, lo: 8'hFF, hi: 8'h00, lat: 2};
        tbl[5] = '{p: 1, x: 8'h7F, y: 8'h80, s: 1, f: 1, hold: 5, lo: 8'h80, hi: 8'hC0, lat: 3};
        tbl[6] = '{p: 0, x: 8'h00, y: 8'hFF, s: 0, f: 1, hold: 2, lo: 8'h00, hi: 8'h00, lat: 3};

        rst = 1'b1;
        in_valid = 2'b11; out_ready = 2'b11;
        in_signed = 2'b00; in_full = 2'b00;
        in_x0 = 8'h12; in_y0 = 8'h34; in_x1 = 8'h56; in_y1 = 8'h78;

        // Reset state, with requests and result-ready already asserted
        repeat (2) @(negedge clk);
        chk("rst/in_ready", 32'(in_ready), 32'd0);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/out_lo", 32'(out_lo), 32'd0);
        chk("rst/out_hi", 32'(out_hi), 32'd0);

        // Both ports always valid from reset: grants alternate from port 0
        @(posedge clk); #1 rst = 1'b0;
        ngr = 0;
        exp_g = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk("alt/not_both", 32'(in_ready == 2'b11), 32'd0);
            if (in_ready != 2'b00) begin
                chk("alt/grant", 32'(in_ready), 32'(2'b01 << exp_g));
                exp_g = 1 - exp_g;
                ngr++;
            end
        end
        chk("alt/grant_count_ge6", 32'(ngr >= 6), 32'd1);
        @(posedge clk); #1 in_valid = 2'b00;
        out_ready = 2'b00;
        do_reset();

        foreach (tbl[i])
            txn($sformatf("vec%0d", i), tbl[i].p, 1'b0, tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].f,
                tbl[i].hold, tbl[i].lo, tbl[i].hi, tbl[i].lat);

        // Randomized traffic; ties must go to the port not served last
        for (int k = 0; k < 40; k++) begin
            both = 1'($urandom_range(0, 1));
            p    = both ? 1 - last : int'($urandom_range(0, 1));
            rx   = 8'($urandom);
            ry   = 8'($urandom);
            rs   = 1'($urandom);
            rf   = 1'($urandom);
            ref_mul(rx, ry, rs, rf, elo, ehi);
            txn($sformatf("rnd%0d", k), p, both, rx, ry, rs, rf,
                int'($urandom_range(0, 3)), elo, ehi, rf ? 3 : 2);
        end

        // Reset pulsed while the high half is being computed
        @(posedge clk); #1;
        set_port(0, 8'hFD, 8'h05, 1'b1, 1'b1);
        in_valid = 2'b01;
        @(posedge clk); #1;
        in_valid = 2'b00;
        out_ready = 2'b11;
        @(posedge clk); #2;
        chk("abort/busy_in_hi", 32'(busy), 32'd1);
        rst = 1'b1;
        in_valid = 2'b11;
        #1;
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/out_valid", 32'(out_valid), 32'd0);
        chk("abort/in_ready", 32'(in_ready), 32'd0);
        chk("abort/out_lo", 32'(out_lo), 32'd0);
        chk("abort/out_hi", 32'(out_hi), 32'd0);
        @(posedge clk); #1;
        in_valid = 2'b00;
        rst = 1'b0;
        last = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort/no_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 2'b00;
        ref_mul(8'h05, 8'hFB, 1'b1, 1'b1, elo, ehi);
        txn("after_abort_tie", 0, 1'b1, 8'h05, 8'hFB, 1'b1, 1'b1, 0, elo, ehi, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
